chain_master: RTL and testbench
===============================

# chain_master

Host-side master for the daisy-chain serial link; it sits directly upstream of `serial_ctrl`. It accepts parallel reset/write/read requests from system logic and turns each one into framed command and data sequences on the single-wire bidirectional line. It samples read-back data from the line during the turnaround window.

## Interface
- `DATA_LEN`, default 8: payload width. Comes from the shared package and must match `serial_ctrl`.
- `GAP_CYCLES`, default 4: idle cycles, line driven 0, inserted after every frame and data burst.
- `TURN_CYCLES`, default 2: released-line cycles between the end of the START_SND frame and the first sampled data bit.
- `clk` in 1: single clock. All logic uses the rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `req_valid` in 1: a request is present.
- `req_ready` out 1: the block can accept a request. High only in IDLE.
- `req_op` in 2: operation, type `chain_op_t`. Values: OP_RESET=0, OP_WRITE=1, OP_READ=2.
- `req_wdata` in DATA_LEN: write payload. Captured on accept.
- `rsp_valid` out 1: one-cycle pulse when the operation completes.
- `rsp_err` out 1: qualified by `rsp_valid`. Set when the op encoding is illegal.
- `rsp_rdata` out DATA_LEN: read result. Holds its value until the next read completes.
- `ser_out` out 1: value driven onto the line.
- `ser_oe` out 1: line drive enable. The top-level tri-state is `line = ser_oe ? ser_out : 'z`.
- `ser_in` in 1: line value sampled by the master.

## Operation
- Accept happens on the rising edge where `req_valid && req_ready`. `req_op` and `req_wdata` are registered at that edge.
- Frame(cmd) is:
  - 1 cycle of `ser_out=1` (start bit);
  - `CMD_LEN` cycles of `cmd` bits, MSB first;
  - 1 cycle of `ser_out=0` (trailer).
- Burst(d) is:
  - `DATA_LEN` cycles of `d` bits, MSB first;
  - 1 trailer cycle of 0.
- OP_RESET: Frame(RESET_CMD), then GAP, then DONE.
- OP_WRITE, in order:
  - Frame(START_RCV_CMD);
  - 1 idle cycle;
  - Burst(wdata), then GAP;
  - Frame(UPDATE_CMD), then GAP, then DONE.
- OP_READ, in order:
  - Frame(START_SND_CMD);
  - `ser_oe=0` for TURN_CYCLES cycles;
  - `ser_oe=0` for DATA_LEN cycles, sampling `ser_in` MSB first into a shift register;
  - 1 released cycle;
  - `ser_oe=1`, `ser_out=0`, then GAP, then DONE.
  - `rsp_rdata` updates in DONE.
- Illegal op (3): no line activity. DONE follows on the next cycle with `rsp_err=1`.
- States: IDLE, START, CMD, TRAIL, IDLE1, DATA, TURN, RECV, REL, GAP, DONE.
  - A per-op sequence step register selects the next frame after GAP.
  - DONE always returns to IDLE.
- Outside RECV/TURN/REL, `ser_oe=1`. In idle, `ser_out=0`.

## Timing
- Reset values: `req_ready=1`, `rsp_valid=0`, `rsp_err=0`, `rsp_rdata=0`, `ser_out=0`, `ser_oe=1`. State is IDLE.
- Reset mid-operation aborts immediately and asynchronously. The line returns to driven 0 and the partial frame is abandoned; no `rsp_valid` is produced.
- The first start bit appears on `ser_out` in the cycle after accept.
- Total latency from accept to `rsp_valid` (C = CMD_LEN, F = C + 2):
  - OP_RESET: F + GAP + 1.
  - OP_WRITE: 2F + 1 + DATA_LEN + 1 + 2·GAP + 1.
  - OP_READ: F + TURN + DATA_LEN + 1 + 1 + GAP + 1.
- `req_ready` is 0 from the accept edge through DONE and returns to 1 in the cycle after DONE. Back-to-back requests therefore have one IDLE cycle between them.
- `req_valid` while not ready is ignored; the requester holds it.
- The bit counter counts down from width−1 to 0. Counter width is $clog2 of the larger of CMD_LEN, DATA_LEN, GAP_CYCLES and TURN_CYCLES, plus 1; it never wraps.

## Structure
- These belong in the shared package, alongside the existing `ctrl_cmd_t` and its values (RESET_CMD, START_RCV_CMD, UPDATE_CMD, START_SND_CMD), `CMD_LEN` and `DATA_LEN`:
  - `chain_op_t`;
  - the state enum `chain_mst_state_t`.
- One sub-module, `chain_shift`: a loadable MSB-first shift register with a down-counter and serial in/out.
  - It has `load`, `shift` and `last` signals.
  - It is reused for command, data-out and data-in.

## Test plan
- Assert `rst_n` low, release, idle 3 cycles → outputs hold their reset values; `req_ready=1`; `ser_oe=1`; `ser_out=0` throughout.
- OP_RESET → line shows start bit, RESET_CMD MSB first, then 0. `rsp_valid` arrives exactly F+GAP+1 cycles after accept and `serial_ctrl` reaches RESET_ST.
- OP_WRITE with 8'h48 → `ser_out` carries START_RCV frame, idle bit, 0,1,0,0,1,0,0,0, trailer, then UPDATE frame. The `serial_ctrl` output register equals 8'h48.
- OP_READ after the write, with `serial_ctrl` attached → `ser_oe=0` exactly during TURN+DATA_LEN+1 cycles. `rsp_rdata=8'h48`, `rsp_err=0`.
- OP_READ against a bench model driving 8'hA5 after 2 turnaround cycles → `rsp_rdata=8'hA5`. Changing `ser_in` outside the RECV window does not affect the result.
- Two scenarios on aborts and illegal ops:
  - Pull `rst_n` low mid-write during the data burst → no `rsp_valid`; outputs return to reset values asynchronously; a following write of 8'h3C completes correctly.
  - `req_op=3` → `rsp_valid` and `rsp_err` are 1 two cycles after accept; no start bit appears.

Source files
------------

// File: rtl/chain_master_pkg.sv
// Shared definitions for the daisy-chain link: command codes, master ops and
// master FSM states, plus small helpers used by chain_master.
package chain_master_pkg;

    localparam int CMD_LEN  = 4;
    localparam int DATA_LEN = 8;

    typedef enum logic [CMD_LEN-1:0] {
        RESET_CMD     = 4'hA,
        START_RCV_CMD = 4'h5,
        UPDATE_CMD    = 4'h3,
        START_SND_CMD = 4'hC
    } ctrl_cmd_t;

    typedef enum logic [1:0] {
        OP_RESET = 2'd0,
        OP_WRITE = 2'd1,
        OP_READ  = 2'd2
    } chain_op_t;

    localparam logic [1:0] OP_ILLEGAL = 2'd3;

    typedef enum logic [3:0] {
        ST_IDLE  = 4'd0,
        ST_START = 4'd1,
        ST_CMD   = 4'd2,
        ST_TRAIL = 4'd3,
        ST_IDLE1 = 4'd4,
        ST_DATA  = 4'd5,
        ST_TURN  = 4'd6,
        ST_RECV  = 4'd7,
        ST_REL   = 4'd8,
        ST_GAP   = 4'd9,
        ST_DONE  = 4'd10
    } chain_mst_state_t;

    // First frame sent for each op; illegal ops never reach the line.
    function automatic logic [CMD_LEN-1:0] op_cmd(input logic [1:0] op);
        case (op)
            OP_RESET: op_cmd = RESET_CMD;
            OP_WRITE: op_cmd = START_RCV_CMD;
            OP_READ:  op_cmd = START_SND_CMD;
            default:  op_cmd = RESET_CMD;
        endcase
    endfunction

    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b; else m = m;
        if (c > m) m = c; else m = m;
        if (d > m) m = d; else m = m;
        return m;
    endfunction

endpackage

// File: rtl/chain_master_shift.sv
// Loadable MSB-first shift register with a saturating down-counter; shared by
// command, data-out, data-in and the gap/turnaround timers.
module chain_shift #(
    parameter int W  = 8,
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic [W-1:0]  load_data,
    input  logic [CW-1:0] load_cnt,
    input  logic          shift,
    input  logic          ser_i,
    output logic          ser_next_o,
    output logic [W-1:0]  data_o,
    output logic          last
);

    logic [W-1:0]  data_q, data_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Next-state: load wins over shift; the counter stops at zero.
    always_comb begin
        data_d = data_q;
        cnt_d  = cnt_q;
        if (load) begin
            data_d = load_data;
            cnt_d  = load_cnt;
        end else if (shift) begin
            data_d = {data_q[W-2:0], ser_i};
            if (cnt_q != {CW{1'b0}}) cnt_d = cnt_q - {{(CW-1){1'b0}}, 1'b1};
            else                     cnt_d = cnt_q;
        end else begin
            data_d = data_q;
        end
    end

    // Shift and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= {W{1'b0}};
            cnt_q  <= {CW{1'b0}};
        end else begin
            data_q <= data_d;
            cnt_q  <= cnt_d;
        end
    end

    assign ser_next_o = data_d[W-1];
    assign data_o     = data_q;
    assign last       = (cnt_q == {CW{1'b0}});

endmodule

// File: rtl/chain_master.sv
// Host-side daisy-chain master: turns reset/write/read requests into framed
// sequences on a single bidirectional line and collects read-back data.
module chain_master
    import chain_master_pkg::*;
#(
    parameter int GAP_CYCLES  = 4,
    parameter int TURN_CYCLES = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [1:0]          req_op,
    input  logic [DATA_LEN-1:0] req_wdata,
    output logic                rsp_valid,
    output logic                rsp_err,
    output logic [DATA_LEN-1:0] rsp_rdata,
    output logic                ser_out,
    output logic                ser_oe,
    input  logic                ser_in
);

    localparam int SW = (CMD_LEN > DATA_LEN) ? CMD_LEN : DATA_LEN;
    localparam int CW = $clog2(max4(CMD_LEN, DATA_LEN, GAP_CYCLES, TURN_CYCLES)) + 1;

    chain_mst_state_t    state_q, state_d;
    logic [1:0]          op_q, op_d;
    logic [1:0]          step_q, step_d;
    logic [DATA_LEN-1:0] wdata_q, wdata_d;
    logic [DATA_LEN-1:0] hold_q, hold_d;
    logic [DATA_LEN-1:0] rdata_q, rdata_d;
    logic                err_q, err_d;
    logic ser_out_q, ser_out_d, ser_oe_q, ser_oe_d;
    logic req_ready_q, req_ready_d, rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;

    logic          load_s, shift_s, sh_next_s, sh_last_s;
    logic [SW-1:0] load_data_s, sh_data_s;
    logic [CW-1:0] load_cnt_s;

    function automatic logic [SW-1:0] align_cmd(input logic [CMD_LEN-1:0] c);
        return SW'(c) << (SW - CMD_LEN);
    endfunction

    chain_shift #(.W(SW), .CW(CW)) u_shift (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load_s),
        .load_data  (load_data_s),
        .load_cnt   (load_cnt_s),
        .shift      (shift_s),
        .ser_i      (ser_in),
        .ser_next_o (sh_next_s),
        .data_o     (sh_data_s),
        .last       (sh_last_s)
    );

    // Next-state logic; step_q tracks which frame of a write/read comes next.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        step_d      = step_q;
        wdata_d     = wdata_q;
        hold_d      = hold_q;
        rdata_d     = rdata_q;
        err_d       = err_q;
        load_s      = 1'b0;
        shift_s     = 1'b0;
        load_data_s = {SW{1'b0}};
        load_cnt_s  = {CW{1'b0}};
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    op_d    = req_op;
                    wdata_d = req_wdata;
                    step_d  = 2'd0;
                    err_d   = (req_op == OP_ILLEGAL);
                    if (req_op == OP_ILLEGAL) begin
                        state_d = ST_TRAIL;
                    end else begin
                        state_d     = ST_START;
                        load_s      = 1'b1;
                        load_data_s = align_cmd(op_cmd(req_op));
                        load_cnt_s  = CW'(CMD_LEN - 1);
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: state_d = ST_CMD;
            ST_CMD: begin
                shift_s = 1'b1;
                if (sh_last_s) state_d = ST_TRAIL; else state_d = ST_CMD;
            end
            ST_TRAIL: begin
                if (err_q) begin
                    state_d = ST_DONE;
                end else if (step_q == 2'd0 && op_q == OP_WRITE) begin
                    state_d = ST_IDLE1;
                    step_d  = 2'd1;
                end else if (step_q == 2'd0 && op_q == OP_READ) begin
                    state_d    = ST_TURN;
                    step_d     = 2'd1;
                    load_s     = 1'b1;
                    load_cnt_s = CW'(TURN_CYCLES - 1);
                end else begin
                    state_d    = ST_GAP;
                    load_s     = 1'b1;
                    load_cnt_s = CW'(GAP_CYCLES - 1);
                end
            end
            ST_IDLE1: begin
                state_d     = ST_DATA;
                load_s      = 1'b1;
                load_data_s = SW'(wdata_q) << (SW - DATA_LEN);
                load_cnt_s  = CW'(DATA_LEN - 1);
            end
            ST_DATA: begin
                shift_s = 1'b1;
                if (sh_last_s) state_d = ST_TRAIL; else state_d = ST_DATA;
            end
            ST_TURN: begin
                shift_s = 1'b1;
                if (sh_last_s) begin
                    state_d    = ST_RECV;
                    load_s     = 1'b1;
                    load_cnt_s = CW'(DATA_LEN - 1);
                end else begin
                    state_d = ST_TURN;
                end
            end
            ST_RECV: begin
                shift_s = 1'b1;
                if (sh_last_s) state_d = ST_REL; else state_d = ST_RECV;
            end
            ST_REL: begin
                hold_d  = sh_data_s[DATA_LEN-1:0];
                state_d = ST_TRAIL;
            end
            ST_GAP: begin
                shift_s = 1'b1;
                if (!sh_last_s) begin
                    state_d = ST_GAP;
                end else if (op_q == OP_WRITE && step_q == 2'd1) begin
                    state_d     = ST_START;
                    step_d      = 2'd2;
                    load_s      = 1'b1;
                    load_data_s = align_cmd(UPDATE_CMD);
                    load_cnt_s  = CW'(CMD_LEN - 1);
                end else begin
                    state_d = ST_DONE;
                    if (op_q == OP_READ) rdata_d = hold_q; else rdata_d = rdata_q;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Output values for the coming cycle, so every port comes from a flop.
    always_comb begin
        ser_oe_d    = !(state_d inside {ST_TURN, ST_RECV, ST_REL});
        ser_out_d   = (state_d == ST_START) ||
                      ((state_d == ST_CMD || state_d == ST_DATA) && sh_next_s);
        req_ready_d = (state_d == ST_IDLE);
        rsp_valid_d = (state_d == ST_DONE);
        rsp_err_d   = (state_d == ST_DONE) && err_d;
    end

    // State, context and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            op_q        <= 2'd0;
            step_q      <= 2'd0;
            wdata_q     <= {DATA_LEN{1'b0}};
            hold_q      <= {DATA_LEN{1'b0}};
            rdata_q     <= {DATA_LEN{1'b0}};
            err_q       <= 1'b0;
            ser_out_q   <= 1'b0;
            ser_oe_q    <= 1'b1;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            step_q      <= step_d;
            wdata_q     <= wdata_d;
            hold_q      <= hold_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
            ser_out_q   <= ser_out_d;
            ser_oe_q    <= ser_oe_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rdata_q;
    assign ser_out   = ser_out_q;
    assign ser_oe    = ser_oe_q;

endmodule

// File: tb/tb_chain_master.sv
// Self-checking bench for chain_master: per-cycle line waveform and response
// timing predicted from the framing rules, plus abort and illegal-op cases.
module tb_chain_master;
    import chain_master_pkg::*;

    localparam int GAP  = 4;
    localparam int TURN = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [1:0] req_op = 2'd0;
    logic [7:0] req_wdata = 8'h00;
    logic       rsp_valid, rsp_err;
    logic [7:0] rsp_rdata;
    logic       ser_out, ser_oe;
    logic       ser_in = 1'b0;

    int compared = 0;
    int mismatched = 0;

    bit exp_oe[$];
    bit exp_out[$];
    int recv_lo;
    logic [7:0] prev_rd = 8'h00;
    logic [7:0] slave_mem = 8'h00;

    typedef struct {
        logic [1:0] op;
        logic [7:0] wdata;
        logic [7:0] drive;
        bit         exp_err;
        logic [7:0] exp_rdata;
    } vec_t;

    vec_t vecs[6];

    chain_master #(.GAP_CYCLES(GAP), .TURN_CYCLES(TURN)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_err   (rsp_err),
        .rsp_rdata (rsp_rdata),
        .ser_out   (ser_out),
        .ser_oe    (ser_oe),
        .ser_in    (ser_in)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input bit oe, input bit o);
        exp_oe.push_back(oe);
        exp_out.push_back(o);
    endtask

    task automatic frame(input logic [CMD_LEN-1:0] cmd);
        push(1'b1, 1'b1);
        for (int i = CMD_LEN - 1; i >= 0; i--) push(1'b1, cmd[i]);
        push(1'b1, 1'b0);
    endtask

    task automatic gap();
        for (int i = 0; i < GAP; i++) push(1'b1, 1'b0);
    endtask

    // Expected line activity for one op, one entry per cycle after accept.
    task automatic build(input logic [1:0] op, input logic [7:0] wd);
        exp_oe.delete();
        exp_out.delete();
        recv_lo = -1;
        case (op)
            2'd0: begin frame(RESET_CMD); gap(); end
            2'd1: begin
                frame(START_RCV_CMD);
                push(1'b1, 1'b0);
                for (int i = 7; i >= 0; i--) push(1'b1, wd[i]);
                push(1'b1, 1'b0);
                gap();
                frame(UPDATE_CMD);
                gap();
            end
            2'd2: begin
                frame(START_SND_CMD);
                for (int i = 0; i < TURN; i++) push(1'b0, 1'b0);
                recv_lo = exp_oe.size();
                for (int i = 0; i < 8; i++) push(1'b0, 1'b0);
                push(1'b0, 1'b0);
                push(1'b1, 1'b0);
                gap();
            end
            default: push(1'b1, 1'b0);
        endcase
    endtask

    // Issue one request at the current negedge and check every cycle to DONE.
    task automatic run_op(input logic [1:0] op, input logic [7:0] wd, input logic [7:0] drv,
                          input bit exp_err, input logic [7:0] exp_rd);
        int n;
        build(op, wd);
        n = exp_oe.size();
        chk("ready_before", req_ready, 1);
        req_valid = 1'b1;
        req_op    = op;
        req_wdata = wd;
        @(posedge clk);
        #1;
        req_op    = 2'($urandom);
        req_wdata = 8'($urandom);
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            chk($sformatf("oe_c%0d", k), ser_oe, exp_oe[k-1]);
            if (exp_oe[k-1]) chk($sformatf("out_c%0d", k), ser_out, exp_out[k-1]);
            chk("valid_busy", rsp_valid, 0);
            chk("ready_busy", req_ready, 0);
            chk("rdata_hold", rsp_rdata, prev_rd);
            if (recv_lo >= 0 && (k - 1) >= recv_lo && (k - 1) < recv_lo + 8)
                ser_in = drv[7 - ((k - 1) - recv_lo)];
            else
                ser_in = 1'($urandom);
        end
        @(negedge clk);
        chk("rsp_valid", rsp_valid, 1);
        chk("rsp_err", rsp_err, exp_err);
        chk("rsp_rdata", rsp_rdata, exp_rd);
        chk("ready_done", req_ready, 0);
        chk("oe_done", ser_oe, 1);
        chk("out_done", ser_out, 0);
        req_valid = 1'b0;
        @(negedge clk);
        chk("ready_after", req_ready, 1);
        chk("valid_after", rsp_valid, 0);
        prev_rd = exp_rd;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_ready"}, req_ready, 1);
        chk({tag, "_valid"}, rsp_valid, 0);
        chk({tag, "_err"}, rsp_err, 0);
        chk({tag, "_rdata"}, rsp_rdata, 0);
        chk({tag, "_out"}, ser_out, 0);
        chk({tag, "_oe"}, ser_oe, 1);
    endtask

    initial begin
        vecs[0] = '{2'd0, 8'h00, 8'h00, 1'b0, 8'h00};
        vecs[1] = '{2'd1, 8'h48, 8'h00, 1'b0, 8'h00};
        vecs[2] = '{2'd2, 8'h00, 8'h48, 1'b0, 8'h48};
        vecs[3] = '{2'd2, 8'h00, 8'hA5, 1'b0, 8'hA5};
        vecs[4] = '{2'd3, 8'h00, 8'h00, 1'b1, 8'hA5};
        vecs[5] = '{2'd1, 8'h5A, 8'h00, 1'b0, 8'hA5};

        #12;
        chk_reset_vals("in_reset");
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk_reset_vals("idle");
        end

        for (int i = 0; i < 6; i++)
            run_op(vecs[i].op, vecs[i].wdata, vecs[i].drive, vecs[i].exp_err, vecs[i].exp_rdata);

        // Abort a write in the middle of its data burst.
        req_valid = 1'b1;
        req_op    = 2'd1;
        req_wdata = 8'hF0;
        @(posedge clk);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            chk("abort_valid", rsp_valid, 0);
        end
        #1;
        rst_n = 1'b0;
        #1;
        chk_reset_vals("abort");
        req_valid = 1'b0;
        @(negedge clk);
        chk_reset_vals("abort_hold");
        rst_n = 1'b1;
        prev_rd = 8'h00;
        @(negedge clk);
        run_op(2'd1, 8'h3C, 8'h00, 1'b0, 8'h00);
        slave_mem = 8'h3C;
        run_op(2'd2, 8'h00, slave_mem, 1'b0, slave_mem);

        // Random ops against a simple register model of the downstream slave.
        for (int i = 0; i < 20; i++) begin
            logic [1:0] op;
            logic [7:0] wd;
            op = 2'($urandom_range(0, 3));
            wd = 8'($urandom);
            case (op)
                2'd0: begin run_op(op, wd, 8'h00, 1'b0, prev_rd); slave_mem = 8'h00; end
                2'd1: begin run_op(op, wd, 8'h00, 1'b0, prev_rd); slave_mem = wd; end
                2'd2: run_op(op, wd, slave_mem, 1'b0, slave_mem);
                default: run_op(op, wd, 8'h00, 1'b1, prev_rd);
            endcase
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
